// File: rtl/riscv_regfile_mp_if.sv
// riscv_regfile_mp_if: read/write/reserve/debug/clear bundle of the multi-port register file
interface riscv_regfile_mp_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 1
);
    localparam int AW = $clog2(NREGS);
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                rsv_en;
    logic [AW-1:0]       rsv_addr;
    logic                dbg_req;
    logic [AW-1:0]       dbg_addr;
    logic                dbg_ack;
    logic [XLEN-1:0]     dbg_rdata;
    logic                clr_start;
    logic                clr_busy;
    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, dbg_req, dbg_addr, clr_start,
        input  rd_data, rd_busy, dbg_ack, dbg_rdata, clr_busy
    );
    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, dbg_req, dbg_addr, clr_start,
        output rd_data, rd_busy, dbg_ack, dbg_rdata, clr_busy
    );
endinterface

// File: rtl/riscv_regfile_mp.sv
// riscv_regfile_mp: N-read/M-write register file with x0, bypass, pending bits,
// a one-cycle debug read port and a sequenced bulk-clear engine.
module riscv_regfile_mp #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter bit BYPASS = 1'b1
) (
    input logic clk,
    input logic rst,
    riscv_regfile_mp_if.slave bus
);
    localparam int AW = $clog2(NREGS);
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t state, state_n;
    logic [AW-1:0] cnt, cnt_n;
    logic [XLEN-1:0] regs [NREGS];
    logic [NREGS-1:0] busy;
    logic last;
    assign last = cnt == AW'(NREGS - 1);
    always_comb begin
        state_n = state == IDLE ? (bus.clr_start ? CLEAR : IDLE) : (last ? IDLE : CLEAR);
        cnt_n   = state == IDLE ? (bus.clr_start ? AW'(1) : cnt) : (last ? '0 : cnt + AW'(1));
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end
    // later non-blocking assignments win: highest write port, then reserve over write-clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) regs[r] <= '0;
            busy <= '0;
        end else if (state == CLEAR) begin
            regs[cnt] <= '0;
            busy[cnt] <= 1'b0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (bus.wr_en[j] && bus.wr_addr[j*AW +: AW] != '0) begin
                    regs[bus.wr_addr[j*AW +: AW]] <= bus.wr_data[j*XLEN +: XLEN];
                    busy[bus.wr_addr[j*AW +: AW]] <= 1'b0;
                end
            end
            if (bus.rsv_en && bus.rsv_addr != '0) busy[bus.rsv_addr] <= 1'b1;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.dbg_ack   <= 1'b0;
            bus.dbg_rdata <= '0;
        end else begin
            bus.dbg_ack <= bus.dbg_req;
            if (bus.dbg_req) bus.dbg_rdata <= regs[bus.dbg_addr];
        end
    end
    assign bus.clr_busy = state == CLEAR;
    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] ra;
        logic [XLEN-1:0] rv;
        assign ra = bus.rd_addr[i*AW +: AW];
        // forwarding is suppressed while clearing since those writes are discarded
        always_comb begin
            rv = regs[ra];
            for (int j = 0; j < NWR; j++)
                if (BYPASS && state == IDLE && bus.wr_en[j] && bus.wr_addr[j*AW +: AW] == ra)
                    rv = bus.wr_data[j*XLEN +: XLEN];
            if (ra == '0) rv = '0;
        end
        assign bus.rd_data[i*XLEN +: XLEN] = rv;
        assign bus.rd_busy[i] = busy[ra];
    end
endmodule

// File: tb/tb_riscv_regfile_mp.sv
// tb_riscv_regfile_mp: scoreboard bench for the multi-port register file; a second
// instance with forwarding disabled shares all inputs with the main one.
module tb_riscv_regfile_mp;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] e;
    riscv_regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) b0 ();
    riscv_regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) b1 ();
    riscv_regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst), .bus(b0.slave));
    riscv_regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .bus(b1.slave));
    assign b1.rd_addr   = b0.rd_addr;
    assign b1.wr_en     = b0.wr_en;
    assign b1.wr_addr   = b0.wr_addr;
    assign b1.wr_data   = b0.wr_data;
    assign b1.rsv_en    = b0.rsv_en;
    assign b1.rsv_addr  = b0.rsv_addr;
    assign b1.dbg_req   = b0.dbg_req;
    assign b1.dbg_addr  = b0.dbg_addr;
    assign b1.clr_start = b0.clr_start;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic idle_in;
        b0.rd_addr = '0; b0.wr_en = '0; b0.wr_addr = '0; b0.wr_data = '0;
        b0.rsv_en = 1'b0; b0.rsv_addr = '0; b0.dbg_req = 1'b0; b0.dbg_addr = '0;
        b0.clr_start = 1'b0;
    endtask
    task automatic wr1(input int a, input logic [31:0] d);
        b0.wr_en = 2'b01; b0.wr_addr = {5'd0, 5'(a)}; b0.wr_data = {32'h0, d};
        tick();
        b0.wr_en = '0;
    endtask
    task automatic rd(input int a0, input int a1);
        b0.rd_addr = {5'(a1), 5'(a0)};
        #1;
    endtask

    task automatic test_reset;
        wr1(1, 32'h5);
        b0.rsv_en = 1'b1; b0.rsv_addr = 5'd2;
        b0.dbg_req = 1'b1; b0.dbg_addr = 5'd1;
        tick();
        idle_in();
        rd(1, 2);
        checks++;
        if (b0.dbg_ack !== 1'b1 || b0.dbg_rdata !== 32'h5 || b0.rd_busy[1] !== 1'b1) begin
            failures++; $display("FAIL pre_reset ack=%b rdata=%h busy=%b want 1/5/1", b0.dbg_ack, b0.dbg_rdata, b0.rd_busy[1]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (b0.rd_data !== 64'h0) begin failures++; $display("FAIL reset_rd_data got=%h want 0", b0.rd_data); end
        checks++;
        if (b0.rd_busy !== 2'b00) begin failures++; $display("FAIL reset_rd_busy got=%b want 00", b0.rd_busy); end
        checks++;
        if (b0.dbg_ack !== 1'b0 || b0.dbg_rdata !== 32'h0) begin
            failures++; $display("FAIL reset_dbg ack=%b rdata=%h want 0/0", b0.dbg_ack, b0.dbg_rdata);
        end
        checks++;
        if (b0.clr_busy !== 1'b0) begin failures++; $display("FAIL reset_clr_busy got=%b want 0", b0.clr_busy); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        b0.wr_en = 2'b01; b0.wr_addr = '0; b0.wr_data = {32'h0, 32'hDEADBEEF};
        exp_q.push_back(32'h0);
        rd(0, 0);
        e = exp_q.pop_front();
        checks++;
        if (b0.rd_data[31:0] !== e) begin failures++; $display("FAIL x0_same_cycle got=%h want %h", b0.rd_data[31:0], e); end
        exp_q.push_back(32'h0);
        tick();
        b0.wr_en = '0;
        rd(0, 0);
        e = exp_q.pop_front();
        checks++;
        if (b0.rd_data[31:0] !== e || b0.rd_busy[0] !== 1'b0) begin
            failures++; $display("FAIL x0_after_write got=%h busy=%b want %h/0", b0.rd_data[31:0], b0.rd_busy[0], e);
        end
    endtask

    task automatic test_conflict;
        b0.wr_en = 2'b11; b0.wr_addr = {5'd5, 5'd5}; b0.wr_data = {32'h22, 32'h11};
        exp_q.push_back(32'h22);
        tick();
        b0.wr_en = '0;
        rd(5, 5);
        e = exp_q.pop_front();
        checks++;
        if (b0.rd_data[31:0] !== e) begin failures++; $display("FAIL write_conflict got=%h want %h", b0.rd_data[31:0], e); end
    endtask

    task automatic test_bypass;
        wr1(7, 32'h1234);
        b0.wr_en = 2'b01; b0.wr_addr = {5'd0, 5'd7}; b0.wr_data = {32'h0, 32'hA5A5A5A5};
        rd(7, 7);
        checks++;
        if (b0.rd_data !== {2{32'hA5A5A5A5}}) begin failures++; $display("FAIL bypass_on got=%h want a5a5a5a5 x2", b0.rd_data); end
        checks++;
        if (b1.rd_data[31:0] !== 32'h1234) begin failures++; $display("FAIL bypass_off got=%h want 00001234", b1.rd_data[31:0]); end
        tick();
        b0.wr_en = '0;
        checks++;
        if (b1.rd_data[63:32] !== 32'hA5A5A5A5) begin failures++; $display("FAIL after_write_nb got=%h want a5a5a5a5", b1.rd_data[63:32]); end
        b0.wr_en = 2'b11; b0.wr_addr = {5'd7, 5'd7}; b0.wr_data = {32'hBBBB, 32'hAAAA};
        #1;
        checks++;
        if (b0.rd_data[63:32] !== 32'hBBBB) begin failures++; $display("FAIL bypass_tie got=%h want 0000bbbb", b0.rd_data[63:32]); end
        tick();
        b0.wr_en = '0;
    endtask

    task automatic test_scoreboard;
        b0.rsv_en = 1'b1; b0.rsv_addr = 5'd9;
        rd(9, 0);
        checks++;
        if (b0.rd_busy[0] !== 1'b0) begin failures++; $display("FAIL busy_not_bypassed got=%b want 0", b0.rd_busy[0]); end
        tick();
        b0.rsv_en = 1'b0;
        checks++;
        if (b0.rd_busy[0] !== 1'b1) begin failures++; $display("FAIL busy_after_rsv got=%b want 1", b0.rd_busy[0]); end
        wr1(9, 32'h3);
        checks++;
        if (b0.rd_busy[0] !== 1'b0 || b0.rd_data[31:0] !== 32'h3) begin
            failures++; $display("FAIL busy_after_write busy=%b data=%h want 0/3", b0.rd_busy[0], b0.rd_data[31:0]);
        end
        b0.rsv_en = 1'b1; b0.rsv_addr = 5'd9;
        wr1(9, 32'h7);
        b0.rsv_en = 1'b0;
        checks++;
        if (b0.rd_busy[0] !== 1'b1 || b0.rd_data[31:0] !== 32'h7) begin
            failures++; $display("FAIL rsv_and_write busy=%b data=%h want 1/7", b0.rd_busy[0], b0.rd_data[31:0]);
        end
        b0.rsv_en = 1'b1; b0.rsv_addr = 5'd0;
        tick();
        b0.rsv_en = 1'b0;
        rd(0, 0);
        checks++;
        if (b0.rd_busy !== 2'b00) begin failures++; $display("FAIL rsv_x0 got=%b want 00", b0.rd_busy); end
    endtask

    task automatic test_clear;
        int n;
        for (int r = 1; r < 32; r++) wr1(r, 32'h01010101 * r);
        b0.rsv_en = 1'b1; b0.rsv_addr = 5'd10;
        tick();
        b0.rsv_en = 1'b0;
        b0.clr_start = 1'b1;
        rd(31, 10);
        checks++;
        if (b0.rd_data[31:0] !== 32'h1F1F1F1F || b0.rd_busy[1] !== 1'b1 || b0.clr_busy !== 1'b0) begin
            failures++; $display("FAIL pre_clear x31=%h busy10=%b clr_busy=%b want 1f1f1f1f/1/0", b0.rd_data[31:0], b0.rd_busy[1], b0.clr_busy);
        end
        tick();
        b0.wr_en = 2'b01; b0.wr_addr = {5'd0, 5'd3}; b0.wr_data = {32'h0, 32'h333};
        b0.rsv_en = 1'b1; b0.rsv_addr = 5'd4;
        n = 0;
        while (b0.clr_busy === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        idle_in();
        checks++;
        if (n != 31) begin failures++; $display("FAIL clr_busy_cycles got=%0d want 31", n); end
        for (int r = 0; r < 32; r++) begin
            rd(r, r);
            checks++;
            if (b0.rd_data[31:0] !== 32'h0 || b0.rd_busy[1] !== 1'b0) begin
                failures++; $display("FAIL cleared_x%0d data=%h busy=%b want 0/0", r, b0.rd_data[31:0], b0.rd_busy[1]);
            end
        end
        b0.clr_start = 1'b1;
        tick();
        b0.clr_start = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (b0.clr_busy !== 1'b0) begin failures++; $display("FAIL clear_abort got=%b want 0", b0.clr_busy); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        wr1(6, 32'h66);
        rd(6, 6);
        checks++;
        if (b0.clr_busy !== 1'b0 || b0.rd_data[31:0] !== 32'h66) begin
            failures++; $display("FAIL after_abort clr_busy=%b x6=%h want 0/66", b0.clr_busy, b0.rd_data[31:0]);
        end
    endtask

    task automatic test_debug;
        int acks;
        acks = 0;
        b0.wr_en = 2'b11; b0.wr_addr = {5'd2, 5'd1}; b0.wr_data = {32'h2, 32'h1};
        tick();
        wr1(3, 32'h3);
        checks++;
        if (b0.dbg_ack !== 1'b0) begin failures++; $display("FAIL dbg_idle got=%b want 0", b0.dbg_ack); end
        for (int k = 0; k < 5; k++) begin
            b0.dbg_req = k < 3;
            b0.dbg_addr = 5'(k + 1);
            if (k < 3) exp_q.push_back(32'(k + 1));
            if (k == 1) begin b0.wr_en = 2'b01; b0.wr_addr = {5'd0, 5'd2}; b0.wr_data = {32'h0, 32'h99}; end
            tick();
            b0.wr_en = '0;
            checks++;
            if (b0.dbg_ack !== (k < 3)) begin failures++; $display("FAIL dbg_ack_c%0d got=%b want %b", k, b0.dbg_ack, k < 3); end
            if (b0.dbg_ack === 1'b1) begin
                acks++;
                e = exp_q.pop_front();
                checks++;
                if (b0.dbg_rdata !== e) begin failures++; $display("FAIL dbg_rdata_c%0d got=%h want %h", k, b0.dbg_rdata, e); end
            end
        end
        b0.dbg_req = 1'b0;
        checks++;
        if (acks != 3) begin failures++; $display("FAIL dbg_ack_count got=%0d want 3", acks); end
        rd(2, 2);
        checks++;
        if (b0.dbg_rdata !== 32'h3 || b0.rd_data[31:0] !== 32'h99) begin
            failures++; $display("FAIL dbg_hold rdata=%h x2=%h want 3/99", b0.dbg_rdata, b0.rd_data[31:0]);
        end
    endtask

    initial begin
        idle_in();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
        test_reset();
        test_conflict();
        test_bypass();
        test_scoreboard();
        test_clear();
        test_debug();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule
